// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file: DEPTH x WIDTH register file, two tristate read buses, sized
// write port and post-inc/pre-dec step port. Optional: REGFILE_BYPASS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_a,
  input  logic [AW-1:0]    sel_a,
  output logic [WIDTH-1:0] q_a,
  input  logic             en_b,
  input  logic [AW-1:0]    sel_b,
  output logic [WIDTH-1:0] q_b,
  input  logic             s,
  input  logic [AW-1:0]    sel_w,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] d,
  input  logic             step,
  input  logic [AW-1:0]    step_sel,
  input  logic             step_dec,
  input  logic [1:0]       step_size
);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_WORD = 2'b01;
  localparam logic [1:0] c_SZ_LONG = 2'b10;
  localparam logic [1:0] c_SZ_NONE = 2'b11;

  function automatic logic [WIDTH-1:0] merge(
    input logic [WIDTH-1:0] old_val,
    input logic [WIDTH-1:0] new_val,
    input logic [1:0]       sz
  );
    logic [WIDTH-1:0] res;
    res = old_val;
    case (sz)
      c_SZ_BYTE: res[7:0]  = new_val[7:0];
      c_SZ_WORD: res[15:0] = new_val[15:0];
      c_SZ_LONG: res       = new_val;
      default:   res       = old_val;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] w_regs [DEPTH];

  logic             w_wr_req;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_wr_val;
  logic             w_step_ok;
  logic [WIDTH-1:0] w_step_amt;
  logic [WIDTH-1:0] w_step_src;
  logic [WIDTH-1:0] w_step_res;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_wr_req   = s && (size != c_SZ_NONE);
  assign w_wr_ok    = w_wr_req && (32'(sel_w) < DEPTH);
  assign w_wr_val   = merge(w_regs[sel_w], d, size);

  assign w_step_ok  = step && (step_size != c_SZ_NONE) && (32'(step_sel) < DEPTH);
  assign w_step_amt = {{(WIDTH-1){1'b0}}, 1'b1} << step_size;
  assign w_step_src = w_regs[step_sel];
  assign w_step_res = step_dec ? (w_step_src - w_step_amt) : (w_step_src + w_step_amt);

  // A write to the same register takes priority over a step; the step is dropped.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [WIDTH-1:0] r_val;
    logic             w_wr_hit;
    logic             w_step_hit;

    assign w_wr_hit   = w_wr_ok && (sel_w == AW'(gi));
    assign w_step_hit = w_step_ok && (step_sel == AW'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val <= '0;
      end else if (w_wr_hit) begin
        r_val <= w_wr_val;
      end else if (w_step_hit) begin
        r_val <= w_step_res;
      end
    end

    assign w_regs[gi] = r_val;
  end

  always_comb begin
    w_rd_a = '0;
    if (32'(sel_a) < DEPTH) begin
      w_rd_a = w_regs[sel_a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && w_wr_req && (sel_a == sel_w)) begin
        w_rd_a = w_wr_val;
      end
`endif
    end
  end

  always_comb begin
    w_rd_b = '0;
    if (32'(sel_b) < DEPTH) begin
      w_rd_b = w_regs[sel_b];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && w_wr_req && (sel_b == sel_w)) begin
        w_rd_b = w_wr_val;
      end
`endif
    end
  end

  assign q_a = en_a ? w_rd_a : {WIDTH{1'bz}};
  assign q_b = en_b ? w_rd_b : {WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// tb_register_file: directed table, hand sequences and randomized model check.
`default_nettype none

module tb_register_file;

  localparam int W = 32;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_a, en_b, s, step, step_dec;
  logic [3:0]   sel_a, sel_b, sel_w, step_sel;
  logic [1:0]   size, step_size;
  logic [W-1:0] d;
  wire  [W-1:0] q_a, q_b;

  int checks = 0;
  int errors = 0;

  register_file #(.WIDTH(W), .DEPTH(N), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .sel_a(sel_a), .q_a(q_a),
    .en_b(en_b), .sel_b(sel_b), .q_b(q_b),
    .s(s), .sel_w(sel_w), .size(size), .d(d),
    .step(step), .step_sel(step_sel), .step_dec(step_dec), .step_size(step_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         s;
    logic [3:0] sel_w;
    logic [1:0] size;
    logic [31:0] d;
    bit         step;
    logic [3:0] step_sel;
    bit         step_dec;
    logic [1:0] step_size;
    logic [3:0] sel_rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] model [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_z(input string name, input bit is_z, input logic [31:0] act);
    checks++;
    if (!is_z) begin
      errors++;
      $display("FAIL %s: got %h want zzzzzzzz", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s = 0; step = 0; size = 2'b11; step_size = 2'b11;
  endtask

  function automatic logic [31:0] mask_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      2'b10:   return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] written(input logic [31:0] old_v, input logic [31:0] nd,
                                          input logic [1:0] sz);
    return (old_v & ~mask_of(sz)) | (nd & mask_of(sz));
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] sel);
    logic [31:0] v;
    v = model[sel];
`ifdef REGFILE_BYPASS_EN
    if (s && size != 2'b11 && sel == sel_w) v = written(model[sel], d, size);
`endif
    return v;
  endfunction

  // Next model state from the inputs currently presented.
  task automatic model_edge();
    logic [31:0] nxt [N];
    longint amt;
    bit wr;
    nxt = model;
    wr = s && size != 2'b11;
    if (wr) nxt[sel_w] = written(model[sel_w], d, size);
    if (step && step_size != 2'b11 && !(wr && sel_w == step_sel)) begin
      amt = longint'(1) << step_size;
      if (step_dec) nxt[step_sel] = 32'((longint'(model[step_sel]) - amt) & 64'hFFFF_FFFF);
      else          nxt[step_sel] = 32'((longint'(model[step_sel]) + amt) & 64'hFFFF_FFFF);
    end
    tick();
    model = nxt;
  endtask

  initial begin
    rst_n = 0; en_a = 0; en_b = 0; sel_a = 0; sel_b = 0;
    sel_w = 0; d = 0; step_sel = 0; step_dec = 0;
    idle();

    vecs[0]  = '{1, 4'd2, 2'b10, 32'h12345678, 0, 4'd0, 0, 2'b11, 4'd2, 32'h12345678};
    vecs[1]  = '{1, 4'd2, 2'b00, 32'hAABBCCDD, 0, 4'd0, 0, 2'b11, 4'd2, 32'h123456DD};
    vecs[2]  = '{1, 4'd2, 2'b01, 32'hAABBCCDD, 0, 4'd0, 0, 2'b11, 4'd2, 32'h1234CCDD};
    vecs[3]  = '{1, 4'd2, 2'b11, 32'hFFFFFFFF, 0, 4'd0, 0, 2'b11, 4'd2, 32'h1234CCDD};
    vecs[4]  = '{1, 4'd1, 2'b10, 32'h00000011, 0, 4'd0, 0, 2'b11, 4'd1, 32'h00000011};
    vecs[5]  = '{1, 4'd5, 2'b10, 32'h00000055, 0, 4'd0, 0, 2'b11, 4'd5, 32'h00000055};
    vecs[6]  = '{0, 4'd0, 2'b11, 32'h0,        1, 4'd8, 1, 2'b10, 4'd8, 32'hFFFFFFFC};
    vecs[7]  = '{0, 4'd0, 2'b11, 32'h0,        1, 4'd8, 0, 2'b10, 4'd8, 32'h00000000};
    vecs[8]  = '{1, 4'd8, 2'b10, 32'h00000100, 1, 4'd8, 1, 2'b00, 4'd8, 32'h00000100};
    vecs[9]  = '{0, 4'd0, 2'b11, 32'h0,        1, 4'd8, 1, 2'b11, 4'd8, 32'h00000100};
    vecs[10] = '{1, 4'd3, 2'b10, 32'h0000000A, 1, 4'd9, 0, 2'b01, 4'd9, 32'h00000002};
    vecs[11] = '{0, 4'd0, 2'b11, 32'h0,        0, 4'd0, 0, 2'b11, 4'd3, 32'h0000000A};

    // Reset state
    #3;
    chk_z("rst_qa_z", q_a === 'z, q_a);
    chk_z("rst_qb_z", q_b === 'z, q_b);
    en_a = 1; sel_a = 3;
    #1 chk("rst_qa_r3", q_a, 32'h0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("post_rst_r3", q_a, 32'h0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      s = vecs[i].s; sel_w = vecs[i].sel_w; size = vecs[i].size; d = vecs[i].d;
      step = vecs[i].step; step_sel = vecs[i].step_sel;
      step_dec = vecs[i].step_dec; step_size = vecs[i].step_size;
      tick();
      idle();
      en_a = 1; sel_a = vecs[i].sel_rd;
      #1 chk($sformatf("vec%0d", i), q_a, vecs[i].exp);
    end

    // Two independent buses
    en_a = 1; sel_a = 1; en_b = 1; sel_b = 5;
    #1 chk("bus_a_r1", q_a, 32'h11);
    chk("bus_b_r5", q_b, 32'h55);
    en_b = 0;
    #1 chk_z("bus_b_off_z", q_b === 'z, q_b);
    chk("bus_a_keep", q_a, 32'h11);
    en_b = 1; sel_b = 1;
    #1 chk("bus_same_reg", q_b, 32'h11);
    en_b = 0;

    // Same-cycle write/read: bypass depends on build
    s = 1; sel_w = 4; size = 2'b10; d = 32'h1;
    tick();
    d = 32'h2; sel_a = 4;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre", q_a, 32'h2);
`else
    chk("bypass_pre", q_a, 32'h1);
`endif
    tick();
    idle();
    #1 chk("bypass_post", q_a, 32'h2);

    // Asynchronous reset between edges
    s = 1; sel_w = 0; size = 2'b10; d = 32'hDEAD;
    tick();
    idle();
    sel_a = 0;
    #1 chk("pre_async_r0", q_a, 32'hDEAD);
    rst_n = 0;
    #1 chk("async_r0", q_a, 32'h0);
    sel_a = 2;
    #1 chk("async_r2", q_a, 32'h0);
    rst_n = 1;

    // Randomized run against the model
    rst_n = 0;
    #1 rst_n = 1;
    for (int i = 0; i < N; i++) model[i] = '0;
    for (int c = 0; c < 400; c++) begin
      s = 1'($urandom); sel_w = 4'($urandom); size = 2'($urandom);
      d = $urandom;
      if (($urandom & 3) == 0) d = 32'hFFFF_FFFF;
      step = 1'($urandom); step_sel = 4'($urandom_range(0, 3) == 0 ? sel_w : 4'($urandom));
      step_dec = 1'($urandom); step_size = 2'($urandom);
      if (s && size == 2'b11 && step_sel == sel_w) step = 0;
      en_a = 1'($urandom_range(0, 3) != 0); sel_a = 4'($urandom);
      en_b = 1'($urandom_range(0, 3) != 0);
      sel_b = ($urandom_range(0, 3) == 0) ? sel_w : 4'($urandom);
      #1;
      if (en_a) chk($sformatf("rnd%0d_a", c), q_a, exp_read(sel_a));
      else      chk_z($sformatf("rnd%0d_az", c), q_a === 'z, q_a);
      if (en_b) chk($sformatf("rnd%0d_b", c), q_b, exp_read(sel_b));
      else      chk_z($sformatf("rnd%0d_bz", c), q_b === 'z, q_b);
      model_edge();
    end
    idle();
    en_a = 1;
    for (int i = 0; i < N; i++) begin
      sel_a = 4'(i);
      #1 chk($sformatf("final_r%0d", i), q_a, model[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
